nn_mem_sched: RTL

Sequencer for one single-port synchronous kernel or weight SRAM in the neural-net datapath (active-low CSB/WEB/OEB, `numAddr`-bit address, 32-bit data). On a `learn` pulse it writes a full image of the memory from a streamed source. On a `classify` pulse it sweeps every address and returns each word with a valid strobe for the convolution/FC stage. One instance is placed per memory port (KMEM1/2, WMEM1/2) beside `NeuralNet_cont`.

---
 rtl/nn_mem_pkg.sv | 14 +
 rtl/rd_lat_pipe.sv | 39 +++
 rtl/nn_mem_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/nn_mem_pkg.sv
// Shared types and default sizes for the neural-net memory sequencer.
package nn_mem_pkg;

    localparam int NUM_ADDR_D = 5;
    localparam int DATA_W_D   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } mem_st_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// RD_LAT-deep delay line that tracks {valid, addr} of issued reads until
// the SRAM returns the matching word.
module rd_lat_pipe #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);

    logic [RD_LAT-1:0] r_valid;
    logic [ADDR_W-1:0] r_addr [RD_LAT];

    // NOTE: the address stages are cleared as well as the valids, since
    // rd_addr is a visible output that must read 0 straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_addr[0]  <= i_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign o_valid = r_valid[RD_LAT-1];
    assign o_addr  = r_addr[RD_LAT-1];

endmodule

// File: rtl/nn_mem_sched.sv
// Sequencer for one single-port kernel/weight SRAM: full-image write on
// learn, full sweep read with valid strobe on classify.
module nn_mem_sched
    import nn_mem_pkg::*;
#(
    parameter int NUM_ADDR = NUM_ADDR_D,
    parameter int DATA_W   = DATA_W_D,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                learn,
    input  logic                classify,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   mem_q,
    output logic [NUM_ADDR-1:0] mem_add,
    output logic [DATA_W-1:0]   mem_din,
    output logic                mem_csb,
    output logic                mem_web,
    output logic                mem_oeb,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_ADDR-1:0] rd_addr,
    output logic                rd_valid,
    output logic                busy,
    output logic                done
);

    localparam logic [NUM_ADDR-1:0] LAST_ADDR  = '1;
    localparam int                  DRN_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DRN_W-1:0]    DRAIN_LAST = DRN_W'(RD_LAT - 1);

    mem_st_t             r_state, w_state_nxt;
    logic [NUM_ADDR-1:0] r_cnt, w_cnt_nxt;
    logic [DRN_W-1:0]    r_drain, w_drain_nxt;
    logic                r_done, w_done_nxt;
    logic                w_wr_hs;
    logic                w_rd_issue;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drain <= w_drain_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drain_nxt = r_drain;
        w_done_nxt  = 1'b0;
        w_wr_hs     = 1'b0;
        w_rd_issue  = 1'b0;
        case (r_state)
            IDLE: begin
                if (learn) begin
                    w_state_nxt = WRITE;
                    w_cnt_nxt   = '0;
                end else if (classify) begin
                    w_state_nxt = READ;
                    w_cnt_nxt   = '0;
                end
            end
            WRITE: begin
                w_wr_hs = wr_valid;
                if (wr_valid) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            READ: begin
                w_rd_issue = 1'b1;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = '0;
                end
            end
            DRAIN: begin
                // Wait out the SRAM latency so done follows the last rd_valid.
                if (r_drain == DRAIN_LAST) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem_csb  = ~(w_wr_hs | w_rd_issue);
    assign mem_web  = ~w_wr_hs;
    assign mem_oeb  = ~w_rd_issue;
    assign mem_add  = (w_wr_hs | w_rd_issue) ? r_cnt : '0;
    assign mem_din  = w_wr_hs ? wr_data : '0;
    assign wr_ready = (r_state == WRITE);
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign rd_data  = mem_q;

    rd_lat_pipe #(
        .RD_LAT (RD_LAT),
        .ADDR_W (NUM_ADDR)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_issue),
        .i_addr  (r_cnt),
        .o_valid (rd_valid),
        .o_addr  (rd_addr)
    );

endmodule
